// File: rtl/n1_irq_arb.sv
`default_nettype none
// ============================================================================
// Module   : n1_irq_arb
// Purpose  : Interrupt request arbiter for the N1 core. Collects up to
//            IRQ_CNT level-sensitive interrupt sources, picks one winner per
//            arbitration round and presents its 16-bit ISR address to the
//            exception/interrupt aggregator. The request is held until the
//            flow controller acknowledges ISR entry or the source withdraws.
// Config   : N1_IRQ_ARB_RR_EN set -> round-robin arbitration
//            (pointer advances on ack). Unset -> fixed priority, lowest
//            index wins, no pointer register (probe reads 0).
// Ports    : clk_i            module clock
//            sync_rst_i       synchronous reset, active-high
//            irq_src_i        level interrupt requests, bit n = source n
//            irq_en_i         per-source enable mask
//            irq_vec_i        ISR addresses, source n at [16n+15:16n]
//            irq_ack_i        one-cycle strobe: presented request taken
//            irq_req_adr_o    requested ISR address, 0x0000 = no request
//            irq_id_o         index of presented source
//            prb_irq_state_o  FSM state probe
//            prb_irq_ptr_o    round-robin pointer probe
// Revision : 1.0 - initial release
// ============================================================================
module n1_irq_arb #(
    parameter int IRQ_CNT = 8
) (
    input  logic                  clk_i,
    input  logic                  sync_rst_i,
    input  logic [IRQ_CNT-1:0]    irq_src_i,
    input  logic [IRQ_CNT-1:0]    irq_en_i,
    input  logic [16*IRQ_CNT-1:0] irq_vec_i,
    input  logic                  irq_ack_i,
    output logic [15:0]           irq_req_adr_o,
    output logic [3:0]            irq_id_o,
    output logic [1:0]            prb_irq_state_o,
    output logic [3:0]            prb_irq_ptr_o
);

    localparam logic [1:0] c_IDLE    = 2'd0;
    localparam logic [1:0] c_ARB     = 2'd1;
    localparam logic [1:0] c_REQ     = 2'd2;
    localparam logic [1:0] c_CLR     = 2'd3;
    localparam logic [3:0] c_LAST_ID = 4'(IRQ_CNT - 1);

    logic [1:0]  r_state;
    logic [3:0]  r_id;
    // Holds the latched vector while in REQ and is zero otherwise, so it
    // doubles as the registered request output.
    logic [15:0] r_adr;

    // Eligibility and vectors padded to 16 entries so that any 4-bit index
    // is in range; unused entries are never eligible.
    logic [15:0] w_elig;
    logic [15:0] w_vec [16];

    logic        w_found;
    logic [3:0]  w_win_id;

    for (genvar n = 0; n < 16; n++) begin : g_src
        if (n < IRQ_CNT) begin : g_used
            assign w_vec[n]  = irq_vec_i[16*n +: 16];
            assign w_elig[n] = irq_src_i[n] & irq_en_i[n] & (w_vec[n] != 16'h0000);
        end else begin : g_unused
            assign w_vec[n]  = 16'h0000;
            assign w_elig[n] = 1'b0;
        end
    end

`ifdef N1_IRQ_ARB_RR_EN
    logic [3:0] r_ptr;
    logic [4:0] w_sum;

    // Search ascends from the pointer, wrapping modulo IRQ_CNT; the first
    // eligible source found wins.
    always_comb begin
        w_found  = 1'b0;
        w_win_id = 4'd0;
        w_sum    = 5'd0;
        for (int i = 0; i < IRQ_CNT; i++) begin
            w_sum = {1'b0, r_ptr} + 5'(i);
            if (w_sum >= 5'(IRQ_CNT)) begin
                w_sum = w_sum - 5'(IRQ_CNT);
            end
            if (!w_found && w_elig[w_sum[3:0]]) begin
                w_found  = 1'b1;
                w_win_id = w_sum[3:0];
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (sync_rst_i) begin
            r_ptr <= 4'd0;
        end else if (r_state == c_REQ && irq_ack_i) begin
            r_ptr <= (r_id == c_LAST_ID) ? 4'd0 : r_id + 4'd1;
        end
    end

    assign prb_irq_ptr_o = r_ptr;
`else
    // Fixed priority: scan downward so the lowest eligible index is the
    // last one written.
    always_comb begin
        w_found  = 1'b0;
        w_win_id = 4'd0;
        for (int i = IRQ_CNT - 1; i >= 0; i--) begin
            if (w_elig[4'(i)]) begin
                w_found  = 1'b1;
                w_win_id = 4'(i);
            end
        end
    end

    assign prb_irq_ptr_o = 4'd0;
`endif

    always_ff @(posedge clk_i) begin
        if (sync_rst_i) begin
            r_state <= c_IDLE;
            r_id    <= 4'd0;
            r_adr   <= 16'h0000;
        end else begin
            case (r_state)
                c_IDLE: begin
                    if (|w_elig) begin
                        r_state <= c_ARB;
                    end
                end
                c_ARB: begin
                    // Sources may vanish between IDLE and ARB; in that case
                    // nothing is latched.
                    if (w_found) begin
                        r_id    <= w_win_id;
                        r_adr   <= w_vec[w_win_id];
                        r_state <= c_REQ;
                    end else begin
                        r_state <= c_IDLE;
                    end
                end
                c_REQ: begin
                    // Ack has precedence over a coincident withdrawal.
                    if (irq_ack_i) begin
                        r_adr   <= 16'h0000;
                        r_state <= c_CLR;
                    end else if (!w_elig[r_id]) begin
                        r_adr   <= 16'h0000;
                        r_state <= c_IDLE;
                    end
                end
                default: begin
                    // CLR: one idle request cycle gives the aggregator a
                    // clean edge before any re-arbitration.
                    r_state <= c_IDLE;
                end
            endcase
        end
    end

    assign irq_req_adr_o   = r_adr;
    assign irq_id_o        = r_id;
    assign prb_irq_state_o = r_state;

endmodule
`default_nettype wire

// File: tb/tb_n1_irq_arb.sv
`default_nettype none
// ============================================================================
// Module   : tb_n1_irq_arb
// Purpose  : Self-checking bench for n1_irq_arb. Expected requests are pushed
//            to a scoreboard queue when stimulus is driven and popped by a
//            monitor whenever a new request appears on irq_req_adr_o.
//            Honours N1_IRQ_ARB_RR_EN to select the arbitration model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_n1_irq_arb;

    localparam int N = 8;

    logic            clk = 1'b0;
    logic            rst;
    logic [N-1:0]    src;
    logic [N-1:0]    en;
    logic [16*N-1:0] vec;
    logic            ack;
    logic [15:0]     req_adr;
    logic [3:0]      req_id;
    logic [1:0]      st;
    logic [3:0]      ptr;

    int n_total = 0;
    int n_bad   = 0;

    logic [19:0] sb_q[$];   // {address, id}
    logic [3:0]  m_ptr;

    always #5 clk = ~clk;

    n1_irq_arb #(.IRQ_CNT(N)) dut (
        .clk_i           (clk),
        .sync_rst_i      (rst),
        .irq_src_i       (src),
        .irq_en_i        (en),
        .irq_vec_i       (vec),
        .irq_ack_i       (ack),
        .irq_req_adr_o   (req_adr),
        .irq_id_o        (req_id),
        .prb_irq_state_o (st),
        .prb_irq_ptr_o   (ptr)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
        end
    endtask

    // Reference arbitration: first eligible source searching upward from p.
    function automatic logic [3:0] model_win(input logic [N-1:0] s, input logic [N-1:0] e,
                                             input logic [16*N-1:0] v, input int p);
        for (int k = 0; k < N; k++) begin
            int n;
            n = (p + k) % N;
            if (s[n] && e[n] && (v[16*n +: 16] != 16'h0000)) return 4'(n);
        end
        return 4'd0;
    endfunction

    task automatic push_exp();
        logic [3:0] w;
        w = model_win(src, en, vec, int'(m_ptr));
        sb_q.push_back({vec[16*w +: 16], w});
    endtask

    task automatic model_ack(input logic [3:0] id);
`ifdef N1_IRQ_ARB_RR_EN
        m_ptr = (int'(id) == N - 1) ? 4'd0 : id + 4'd1;
`else
        m_ptr = 4'd0;
`endif
    endtask

    task automatic cyc();
        @(negedge clk);
    endtask

    task automatic wait_req(input int budget);
        for (int i = 0; i < budget; i++) begin
            cyc();
            if (req_adr != 16'h0000) return;
        end
        chk("req_timeout", {16'h0, req_adr}, 32'h1);
    endtask

    task automatic do_reset();
        rst = 1'b1; ack = 1'b0; src = '0;
        cyc(); cyc();
        rst = 1'b0;
        m_ptr = 4'd0;
    endtask

    // Monitor: every new request (0 -> nonzero) consumes one expectation.
    initial begin
        logic [15:0] prev;
        logic [19:0] e;
        prev = 16'h0000;
        forever begin
            @(negedge clk);
            if (req_adr != 16'h0000 && prev == 16'h0000) begin
                if (sb_q.size() == 0) begin
                    chk("sb_unexpected", {12'h0, req_adr, req_id}, 32'h0);
                end else begin
                    e = sb_q.pop_front();
                    chk("sb_adr", {16'h0, req_adr}, {16'h0, e[19:4]});
                    chk("sb_id", {28'h0, req_id}, {28'h0, e[3:0]});
                end
            end
            prev = req_adr;
        end
    end

    initial begin
        logic [3:0] exp_id;
        rst = 1'b1; ack = 1'b0; src = '0; en = '1; m_ptr = 4'd0;
        for (int n = 0; n < N; n++) vec[16*n +: 16] = 16'h8000 + 16'(n * 16'h0111) + 16'h1;
        vec[2*16 +: 16] = 16'h1234;

        // ---- reset state
        cyc(); cyc();
        chk("rst_adr", {16'h0, req_adr}, 32'h0);
        chk("rst_id", {28'h0, req_id}, 32'h0);
        chk("rst_state", {30'h0, st}, 32'h0);
        chk("rst_ptr", {28'h0, ptr}, 32'h0);
        rst = 1'b0;
        cyc();

        // ---- single source, latency, hold, ack/CLR, re-presentation
        src = 8'h04;
        push_exp();
        cyc();
        chk("t1_arb_state", {30'h0, st}, 32'h1);
        chk("t1_arb_adr", {16'h0, req_adr}, 32'h0);
        cyc();
        chk("t1_adr", {16'h0, req_adr}, 32'h1234);
        chk("t1_id", {28'h0, req_id}, 32'h2);
        vec[2*16 +: 16] = 16'h5555;
        cyc();
        chk("t1_vec_hold", {16'h0, req_adr}, 32'h1234);
        vec[2*16 +: 16] = 16'h1234;
        ack = 1'b1;
        model_ack(4'd2);
        push_exp();
        cyc();
        ack = 1'b0;
        chk("t1_clr_state", {30'h0, st}, 32'h3);
        chk("t1_clr_adr", {16'h0, req_adr}, 32'h0);
        cyc();
        chk("t1_idle_state", {30'h0, st}, 32'h0);
        cyc(); cyc();
        chk("t1_again_adr", {16'h0, req_adr}, 32'h1234);
        src = '0;
        cyc();
        chk("t1_drop_adr", {16'h0, req_adr}, 32'h0);
        chk("t1_drop_state", {30'h0, st}, 32'h0);

        // ---- sources 0 and 7, ack each request
        do_reset();
        src = 8'h81;
        for (int k = 0; k < 4; k++) begin
            push_exp();
            wait_req(10);
`ifdef N1_IRQ_ARB_RR_EN
            exp_id = (k % 2 == 0) ? 4'd0 : 4'd7;
`else
            exp_id = 4'd0;
`endif
            chk("t2_id", {28'h0, req_id}, {28'h0, exp_id});
            ack = 1'b1;
            model_ack(exp_id);
            if (k == 3) src = '0;
            cyc();
            ack = 1'b0;
            chk("t2_ptr", {28'h0, ptr}, {28'h0, m_ptr});
        end
        cyc(); cyc(); cyc();

        // ---- ack and withdrawal in the same cycle: ack wins
        src = 8'h08;
        push_exp();
        wait_req(10);
        chk("t3_id", {28'h0, req_id}, 32'h3);
        ack = 1'b1; src = '0;
        model_ack(4'd3);
        cyc();
        ack = 1'b0;
        chk("t3_clr_state", {30'h0, st}, 32'h3);
        chk("t3_ptr", {28'h0, ptr}, {28'h0, m_ptr});
        cyc();

        // ---- withdrawal by mask clear: pointer unchanged
        src = 8'h08;
        push_exp();
        wait_req(10);
        chk("t4_id", {28'h0, req_id}, 32'h3);
        en = 8'hF7;
        cyc();
        chk("t4_adr", {16'h0, req_adr}, 32'h0);
        chk("t4_state", {30'h0, st}, 32'h0);
        chk("t4_ptr", {28'h0, ptr}, {28'h0, m_ptr});
        en = '1; src = '0;
        cyc(); cyc();

        // ---- zero vector is never presented
        vec[5*16 +: 16] = 16'h0000;
        vec[6*16 +: 16] = 16'h4000;
        src = 8'h60;
        push_exp();
        wait_req(10);
        chk("t5_adr", {16'h0, req_adr}, 32'h4000);
        chk("t5_id", {28'h0, req_id}, 32'h6);
        ack = 1'b1; src = '0;
        model_ack(4'd6);
        cyc();
        ack = 1'b0;
        chk("t5_ptr", {28'h0, ptr}, {28'h0, m_ptr});
        vec[5*16 +: 16] = 16'h8556;
        cyc(); cyc();

        // ---- reset dominates a coincident ack in REQ
        src = 8'h02;
        push_exp();
        wait_req(10);
        chk("t6_id", {28'h0, req_id}, 32'h1);
        rst = 1'b1; ack = 1'b1; src = '0;
        cyc();
        rst = 1'b0; ack = 1'b0; m_ptr = 4'd0;
        chk("t6_adr", {16'h0, req_adr}, 32'h0);
        chk("t6_id0", {28'h0, req_id}, 32'h0);
        chk("t6_state", {30'h0, st}, 32'h0);
        chk("t6_ptr", {28'h0, ptr}, 32'h0);

        // ---- ack outside REQ is ignored
        ack = 1'b1;
        cyc();
        ack = 1'b0;
        chk("t7_state", {30'h0, st}, 32'h0);
        chk("t7_ptr", {28'h0, ptr}, 32'h0);

        cyc(); cyc(); cyc(); cyc();
        chk("sb_left", 32'(sb_q.size()), 32'h0);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
